// File: rtl/alu_pkg.sv
// Shared widths, FSM state type and word packing for the ALU result UART.
// Imported by the result FIFO and the transmitter top.
package alu_pkg;

  localparam int OP_W       = 2;
  localparam int R_W        = 7;
  localparam int WORD_W     = 10;
  localparam int FRAME_BITS = 12;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // w[6:0]=R, w[8:7]=OP, w[9]=flag
  function automatic logic [WORD_W-1:0] pack_word(
    input logic            flag,
    input logic [OP_W-1:0] op,
    input logic [R_W-1:0]  r
  );
    return {flag, op, r};
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small circular FIFO holding captured ALU result words.
// Ports: clk, rst (async high), push/wdata, pop/rdata (head), count, full, empty.
module result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = WORD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A pop frees the slot this cycle, so a full FIFO still takes the write.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_result_uart_tx.sv
// Captures {flag, OP, R} on res_valid, buffers it and sends it as a serial frame.
// Ports: clk, rst (async high), res_valid/R/OP/flag in; tx, busy, fifo_count, overflow out.
module alu_result_uart_tx
  import alu_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int BAUD_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   res_valid,
  input  logic [R_W-1:0]         R,
  input  logic [OP_W-1:0]        OP,
  input  logic                   flag,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int BW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BITW = $clog2(FRAME_BITS);

  tx_state_e         state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [BITW-1:0]   bit_q, bit_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;

  logic              baud_wrap;
  logic              last_bit;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] head;
  logic [WORD_W-1:0] word;

  assign word = pack_word(flag, OP, R);

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (res_valid),
    .wdata (word),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_wrap = (baud_q == BW'(BAUD_DIV - 1));
  assign last_bit  = (bit_q == BITW'(WORD_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   if (baud_wrap) state_d = DATA;
      DATA:    if (baud_wrap && last_bit) state_d = STOP;
      STOP:    if (baud_wrap) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // tx/busy are registered from the current state, so the line
  // lags the state register by one cycle.
  always_comb begin
    pop    = 1'b0;
    tx_d   = 1'b1;
    busy_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        pop    = !fifo_empty;
      end
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      STOP:    pop  = baud_wrap && !fifo_empty;
      default: busy_d = 1'b0;
    endcase
  end

  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE || baud_wrap) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + 1'b1;
    end
    unique case (1'b1)
      pop: begin
        shift_d = head;
        bit_d   = '0;
      end
      (state_q == DATA && baud_wrap): begin
        shift_d = shift_q >> 1;
        bit_d   = last_bit ? '0 : bit_q + 1'b1;
      end
      default: ;
    endcase
    // Dropped only when full and nothing leaves this cycle.
    if (res_valid && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Self-checking bench for alu_result_uart_tx (BAUD_DIV=4 and BAUD_DIV=1).
// A UART receiver model decodes tx and compares against queued words.
module tb_alu_result_uart_tx;

  localparam int B0    = 4;
  localparam int B1    = 1;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rv0 = 1'b0;
  logic       rv1 = 1'b0;
  logic [6:0] r_in = '0;
  logic [1:0] op_in = '0;
  logic       flag_in = 1'b0;

  logic       tx0, busy0, ovf0;
  logic       tx1, busy1, ovf1;
  logic [3:0] cnt0, cnt1;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  bit rx_abort = 1'b0;
  int busy_cyc = 0;
  int busy_rise = 0;

  alu_result_uart_tx #(.DEPTH(DEPTH), .BAUD_DIV(B0)) dut (
    .clk(clk), .rst(rst), .res_valid(rv0),
    .R(r_in), .OP(op_in), .flag(flag_in),
    .tx(tx0), .busy(busy0), .fifo_count(cnt0), .overflow(ovf0)
  );

  alu_result_uart_tx #(.DEPTH(DEPTH), .BAUD_DIV(B1)) dut1 (
    .clk(clk), .rst(rst), .res_valid(rv1),
    .R(r_in), .OP(op_in), .flag(flag_in),
    .tx(tx1), .busy(busy1), .fifo_count(cnt1), .overflow(ovf1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int mk_word(input int flag, input int op, input int r);
    return flag * 512 + op * 128 + r;
  endfunction

  // Drive one strobe; returns at posedge+1 after the capturing edge.
  task automatic strobe(input bit sel, input int w, input bit accept);
    r_in    = 7'(w % 128);
    op_in   = 2'((w / 128) % 4);
    flag_in = 1'((w / 512) % 2);
    if (sel) rv1 = 1'b1;
    else rv0 = 1'b1;
    @(posedge clk);
    #1;
    rv0 = 1'b0;
    rv1 = 1'b0;
    if (accept && !sel) exp_q.push_back(w);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called right after strobe() into an empty idle block.
  task automatic trace_frame(input bit sel, input int b, input int w);
    int k;
    int e;
    @(negedge clk);
    chk("lat_tx_a", sel ? tx1 : tx0, 1);
    chk("lat_busy_a", sel ? busy1 : busy0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_tx_b", sel ? tx1 : tx0, 1);
    chk("lat_busy_b", sel ? busy1 : busy0, 0);
    for (int c = 0; c < 12 * b; c++) begin
      k = c / b;
      if (k == 0) e = 0;
      else if (k == 11) e = 1;
      else e = (w >> (k - 1)) & 1;
      @(negedge clk);
      chk($sformatf("tx_cyc%0d", c), sel ? tx1 : tx0, e);
      chk("busy_on", sel ? busy1 : busy0, 1);
    end
    @(negedge clk);
    chk("busy_off", sel ? busy1 : busy0, 0);
    chk("tx_idle", sel ? tx1 : tx0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int bound, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy0 || cnt0 != 0) && n < bound) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(tag, n < bound, 1);
    idle(3);
  endtask

  // Receiver model for dut: samples each bit at its centre.
  int   rx_got;
  logic rx_s, rx_p;
  logic tx_prev = 1'b1;
  initial forever begin
    @(negedge clk);
    if (tx_prev && !tx0 && !rst) begin
      rx_got = 0;
      repeat (B0 / 2) @(negedge clk);
      rx_s = tx0;
      for (int i = 0; i < 10; i++) begin
        repeat (B0) @(negedge clk);
        if (tx0) rx_got += (1 << i);
      end
      repeat (B0) @(negedge clk);
      rx_p = tx0;
      if (!rx_abort) begin
        chk("rx_start", rx_s, 0);
        chk("rx_stop", rx_p, 1);
        if (exp_q.size() == 0) chk("rx_unexpected", rx_got, 32'hFFFF);
        else chk("rx_word", rx_got, exp_q.pop_front());
      end
    end
    tx_prev = tx0;
  end

  logic busy_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (busy0) busy_cyc++;
    if (busy0 && !busy_prev) busy_rise++;
    busy_prev = busy0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, b0, r0, seq, last, n, c, len;

    #1 rst = 1'b1;
    #1;
    chk("rst_tx", tx0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_tx_b1", tx1, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // single frame, bit-accurate
    w = mk_word(1, 1, 'h55);
    strobe(0, w, 1);
    trace_frame(0, B0, w);
    wait_drain(200, "t1_drain");

    // 9 back-to-back strobes, then a 10th into a full FIFO
    for (int i = 0; i < 9; i++) strobe(0, int'($urandom_range(0, 1023)), 1);
    @(negedge clk);
    chk("t2_count", cnt0, 8);
    chk("t2_no_ovf", ovf0, 0);
    strobe(0, int'($urandom_range(0, 1023)), 0);
    @(negedge clk);
    chk("t2_ovf", ovf0, 1);
    chk("t2_count_full", cnt0, 8);
    wait_drain(10 * 12 * B0 + 50, "t2_drain");
    chk("t2_ovf_sticky", ovf0, 1);
    rst = 1'b1;
    #2 rst = 1'b0;
    idle(2);
    chk("t2_ovf_clr", ovf0, 0);

    // one frame running, three more queued behind it
    b0 = busy_cyc;
    r0 = busy_rise;
    strobe(0, int'($urandom_range(0, 1023)), 1);
    idle(2);
    for (int i = 0; i < 3; i++) strobe(0, int'($urandom_range(0, 1023)), 1);
    seq = 0;
    last = -1;
    n = 0;
    while (n < 4 * 12 * B0 + 40) begin
      @(negedge clk);
      c = int'(cnt0);
      if (c != last) begin
        seq = seq * 16 + c;
        last = c;
      end
      n++;
      if (!busy0) break;
    end
    chk("t3_cnt_seq", seq, 'h3210);
    chk("t3_busy_cycles", busy_cyc - b0, 4 * 12 * B0);
    chk("t3_busy_rises", busy_rise - r0, 1);
    wait_drain(100, "t3_drain");

    // full FIFO, write lands on the STOP-end pop edge
    strobe(0, int'($urandom_range(0, 1023)), 1);
    for (int i = 0; i < 8; i++) strobe(0, int'($urandom_range(0, 1023)), 1);
    @(negedge clk);
    chk("t4_full", cnt0, 8);
    idle(12 * B0 - 8);
    strobe(0, mk_word(0, 3, 'h7F), 1);
    @(negedge clk);
    chk("t4_count", cnt0, 8);
    chk("t4_no_ovf", ovf0, 0);
    wait_drain(11 * 12 * B0 + 50, "t4_drain");

    // async reset in the middle of DATA
    for (int i = 0; i < 10; i++) strobe(0, int'($urandom_range(0, 1023)), 0);
    idle(B0 + 8);
    chk("t5_pre_busy", busy0, 1);
    chk("t5_pre_ovf", ovf0, 1);
    rx_abort = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t5_tx", tx0, 1);
    chk("t5_busy", busy0, 0);
    chk("t5_count", cnt0, 0);
    chk("t5_ovf", ovf0, 0);
    #1 rst = 1'b0;
    idle(12 * B0 + 4);
    exp_q.delete();
    rx_abort = 1'b0;
    w = mk_word(0, 2, 'h2A);
    strobe(0, w, 1);
    trace_frame(0, B0, w);
    wait_drain(200, "t5_drain");

    // randomized bursts, never more than DEPTH outstanding
    for (int burst = 0; burst < 6; burst++) begin
      len = int'($urandom_range(1, 8));
      for (int j = 0; j < len; j++) begin
        strobe(0, int'($urandom_range(0, 1023)), 1);
        idle(int'($urandom_range(0, 3)));
      end
      wait_drain(9 * 12 * B0 + 100, "rand_drain");
      chk("rand_no_ovf", ovf0, 0);
    end

    // BAUD_DIV=1 instance
    w = mk_word(1, 2, 'h33);
    strobe(1, w, 0);
    trace_frame(1, B1, w);
    chk("b1_count", cnt1, 0);
    chk("b1_ovf", ovf1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
